// File: rtl/tx_pkt_mux.sv
`default_nettype none
// ============================================================================
// tx_pkt_mux : per-channel store-and-forward FIFOs, whole-packet arbitration,
//              RATIO:1 packing onto one wide TX stream.   Rev 1.0
// Optional macro TX_PKT_MUX_STRICT_PRIO_EN: lowest channel index always wins.
// ============================================================================
module tx_pkt_mux #(
  parameter  int CH_NUM     = 2,
  parameter  int IN_BYTES   = 2,
  parameter  int RATIO      = 2,
  parameter  int FIFO_DEPTH = 64,
  localparam int IN_W       = 8 * IN_BYTES,
  localparam int OUT_BYTES  = IN_BYTES * RATIO,
  localparam int OUT_W      = 8 * OUT_BYTES,
  localparam int IN_MW      = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1,
  localparam int OUT_MW     = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1,
  localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM*IN_W-1:0]   din_data,
  input  logic [CH_NUM-1:0]        din_vld,
  input  logic [CH_NUM-1:0]        din_sop,
  input  logic [CH_NUM-1:0]        din_eop,
  input  logic [CH_NUM*IN_MW-1:0]  din_mod,
  output logic [CH_NUM-1:0]        din_rdy,
  output logic [OUT_W-1:0]         tx_data,
  output logic                     tx_vld,
  output logic                     tx_sop,
  output logic                     tx_eop,
  output logic [OUT_MW-1:0]        tx_mod,
  output logic [CH_W-1:0]          tx_ch,
  input  logic                     tx_rdy,
  output logic [CH_NUM-1:0]        ovf_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PH_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ENT_W = IN_W + IN_MW + 2;
  localparam int IDX_W = CH_W + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [CH_NUM-1:0][PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CH_NUM-1:0][CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CH_NUM-1:0]            ovf_q, ovf_d;
  logic [CH_W-1:0]              grant_q, grant_d, rr_q, rr_d, tx_ch_q, tx_ch_d;
  logic [PH_W-1:0]              phase_q, phase_d;
  logic [OUT_W-1:0]             acc_q, acc_d, tx_data_q, tx_data_d;
  logic                         acc_sop_q, acc_sop_d;
  logic                         tx_vld_q, tx_vld_d, tx_sop_q, tx_sop_d, tx_eop_q, tx_eop_d;
  logic [OUT_MW-1:0]            tx_mod_q, tx_mod_d;

  logic [CH_NUM-1:0]            wr_en, rd_sel, eligible;
  logic [CH_NUM-1:0][ENT_W-1:0] ch_head;
  logic                         head_sop, head_eop;
  logic [IN_MW-1:0]             head_mod;
  logic [IN_W-1:0]              head_data;
  logic                         rd_en, last_lane, pick_vld;
  logic [CH_W-1:0]              pick;
  logic [IDX_W-1:0]             rr_idx;
  logic [OUT_W-1:0]             acc_nxt;

  genvar c;
  generate
    for (c = 0; c < CH_NUM; c++) begin : g_ch
      logic [ENT_W-1:0] mem [FIFO_DEPTH];

      always_ff @(posedge clk) begin
        if (wr_en[c]) begin
          mem[wr_ptr_q[c][PTR_W-1:0]] <= {din_sop[c], din_eop[c],
                                          din_mod[c*IN_MW +: IN_MW], din_data[c*IN_W +: IN_W]};
        end
      end

      assign ch_head[c]  = mem[rd_ptr_q[c][PTR_W-1:0]];
      assign din_rdy[c]  = !((wr_ptr_q[c][PTR_W] != rd_ptr_q[c][PTR_W]) &&
                             (wr_ptr_q[c][PTR_W-1:0] == rd_ptr_q[c][PTR_W-1:0]));
      assign wr_en[c]    = din_vld[c] & din_rdy[c];
      assign rd_sel[c]   = rd_en && (grant_q == CH_W'(c));
      // A nonzero count means a complete packet is buffered, so SEND never underruns.
      assign eligible[c] = (pkt_cnt_q[c] != '0);
    end
  endgenerate

  assign {head_sop, head_eop, head_mod, head_data} = ch_head[grant_q];
  assign rd_en     = (state_q == SEND) && tx_rdy;
  assign last_lane = head_eop || (phase_q == PH_W'(RATIO - 1));
  assign acc_nxt   = acc_q | (OUT_W'(head_data) << (IN_W * (RATIO - 1 - int'(phase_q))));

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    rr_idx   = '0;
    for (int i = 0; i < CH_NUM; i++) begin
`ifdef TX_PKT_MUX_STRICT_PRIO_EN
      rr_idx = IDX_W'(i);
`else
      rr_idx = {1'b0, rr_q} + IDX_W'(i);
      if (rr_idx >= IDX_W'(CH_NUM)) rr_idx = rr_idx - IDX_W'(CH_NUM);
`endif
      if (!pick_vld && eligible[rr_idx[CH_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = rr_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    ovf_d     = ovf_q;
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    phase_d   = phase_q;
    acc_d     = acc_q;
    acc_sop_d = acc_sop_q;
    tx_vld_d  = 1'b0;
    tx_data_d = tx_data_q;
    tx_sop_d  = tx_sop_q;
    tx_eop_d  = tx_eop_q;
    tx_mod_d  = tx_mod_q;
    tx_ch_d   = tx_ch_q;

    for (int i = 0; i < CH_NUM; i++) begin
      if (wr_en[i])  wr_ptr_d[i] = wr_ptr_q[i] + (PTR_W + 1)'(1);
      if (rd_sel[i]) rd_ptr_d[i] = rd_ptr_q[i] + (PTR_W + 1)'(1);
      if (din_vld[i] && !din_rdy[i]) ovf_d[i] = 1'b1;
      case ({wr_en[i] & din_eop[i], rd_sel[i] & head_eop})
        2'b10:   pkt_cnt_d[i] = pkt_cnt_q[i] + CNT_W'(1);
        2'b01:   pkt_cnt_d[i] = pkt_cnt_q[i] - CNT_W'(1);
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = SEND;
          grant_d = pick;
          tx_ch_d = pick;
        end
      end
      SEND: begin
        if (tx_rdy) begin
          if (last_lane) begin
            tx_vld_d  = 1'b1;
            tx_data_d = acc_nxt;
            tx_sop_d  = acc_sop_q | head_sop;
            tx_eop_d  = head_eop;
            // Unfilled LS lanes of a short final word count as invalid bytes.
            tx_mod_d  = head_eop ? OUT_MW'(int'(head_mod) + (RATIO - 1 - int'(phase_q)) * IN_BYTES)
                                 : '0;
            acc_d     = '0;
            acc_sop_d = 1'b0;
            phase_d   = '0;
          end else begin
            acc_d     = acc_nxt;
            acc_sop_d = acc_sop_q | head_sop;
            phase_d   = phase_q + PH_W'(1);
          end
          if (head_eop) begin
            state_d = IDLE;
            rr_d    = (grant_q == CH_W'(CH_NUM - 1)) ? '0 : grant_q + CH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      ovf_q     <= '0;
      grant_q   <= '0;
      rr_q      <= '0;
      phase_q   <= '0;
      acc_q     <= '0;
      acc_sop_q <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= '0;
      tx_sop_q  <= 1'b0;
      tx_eop_q  <= 1'b0;
      tx_mod_q  <= '0;
      tx_ch_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovf_q     <= ovf_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      acc_sop_q <= acc_sop_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
      tx_sop_q  <= tx_sop_d;
      tx_eop_q  <= tx_eop_d;
      tx_mod_q  <= tx_mod_d;
      tx_ch_q   <= tx_ch_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_vld  = tx_vld_q;
  assign tx_sop  = tx_sop_q;
  assign tx_eop  = tx_eop_q;
  assign tx_mod  = tx_mod_q;
  assign tx_ch   = tx_ch_q;
  assign ovf_err = ovf_q;

endmodule
`default_nettype wire

// File: doc/tx_pkt_mux.md
Name: tx_pkt_mux

Overview:
- Parametrised successor to the two-input TX packet selector: N input channels of narrow packet streams, each buffered in its own store-and-forward FIFO.
- Whole packets are arbitrated round-robin and packed RATIO:1 into one wide TX stream with sop/eop/mod and a source-channel tag.
- Sits between the MAC/ARP/IP framers and the wide TX datapath.

Parameters:
- CH_NUM, 2, number of input channels (1..8).
- IN_BYTES, 2, bytes per input word; IN_W = 8*IN_BYTES.
- RATIO, 2, input words per output word; OUT_BYTES = IN_BYTES*RATIO, OUT_W = 8*OUT_BYTES.
- FIFO_DEPTH, 64, words per channel FIFO; power of 2.
- Derived widths: IN_MW = max(1, clog2(IN_BYTES)); OUT_MW = max(1, clog2(OUT_BYTES)); CH_W = max(1, clog2(CH_NUM)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- din_data  in  CH_NUM*IN_W  channel c occupies [c*IN_W +: IN_W].
- din_vld  in  CH_NUM  per-channel word valid.
- din_sop  in  CH_NUM  first word of packet.
- din_eop  in  CH_NUM  last word of packet.
- din_mod  in  CH_NUM*IN_MW  invalid bytes in eop word; only meaningful with eop.
- din_rdy  out  CH_NUM  channel FIFO not full.
- tx_data  out  OUT_W  packed output; earliest input word in the MS lane.
- tx_vld  out  1  output word valid (one-cycle pulse per word).
- tx_sop  out  1  first output word of packet.
- tx_eop  out  1  last output word of packet.
- tx_mod  out  OUT_MW  invalid bytes in the eop output word; 0 otherwise.
- tx_ch  out  CH_W  source channel of the current output word.
- tx_rdy  in  1  sink can accept.
- ovf_err  out  CH_NUM  sticky: a word arrived while din_rdy was low.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FIFOs emptied, packet counters 0, RR pointer 0, FSM IDLE. Asserting reset mid-packet discards all buffered data. No partial packet is emitted after reset.
- Input side:
  - Word written when din_vld[c]=1 and din_rdy[c]=1.
  - din_vld with din_rdy=0: word dropped, ovf_err[c] set until reset.
  - din_rdy[c] is combinational: !full[c].
  - Max packet length is FIFO_DEPTH words; longer packets deadlock, which is a documented constraint.
- Packet counter per channel, width clog2(FIFO_DEPTH+1):
  - +1 when an eop word is written; -1 when an eop word is read; unchanged if both happen in the same cycle.
  - Channel is eligible when its count != 0, i.e. a complete packet is stored, so the FIFO never underruns mid-packet.
- FSM IDLE/SEND:
  - IDLE: if any channel is eligible, grant the first eligible channel at or after the RR pointer, set tx_ch, go to SEND. One cycle is spent in IDLE per packet.
  - SEND: read the granted FIFO (first-word-fall-through) each cycle tx_rdy=1. When the eop word is read, go to IDLE and set the RR pointer to grant+1 (mod CH_NUM).
  - tx_rdy=0 stalls reads and holds packing state.
- Packing: phase counter 0..RATIO-1 advances per read.
  - Word at phase p goes to lane RATIO-1-p (MS lane first).
  - A word completes at p=RATIO-1 or on eop. On completion: tx_vld=1 next cycle, phase resets to 0.
  - Early eop: unfilled lanes are 0, and tx_mod = in_mod + (RATIO-1-p)*IN_BYTES.
  - tx_sop=1 on the output word containing the input sop; tx_eop=1 on the word containing eop.
- Latency: output word registered 1 cycle after its final FIFO read.
- Sink protocol: the sink must accept one more tx_vld after dropping tx_rdy (1-word skid).
- A single-word packet (sop&eop) emits one word with sop=eop=1 and tx_mod = in_mod + (RATIO-1)*IN_BYTES.
- Simultaneous eligibility: RR order only. Writes to a channel during its own SEND are allowed.

Optional Feature:
- Macro: TX_PKT_MUX_STRICT_PRIO_EN.
- Defined: arbitration is fixed priority, lowest channel index wins every IDLE decision, and the RR pointer is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both modes.

Test Plan:
- Default parameters; ch0 sends 4 words 0x1111,0x2222,0x3333,0x4444 (mod 0) -> 2 tx words 0x11112222 (sop), 0x33334444 (eop, mod 0), tx_ch=0.
- Ch1 sends 3 words 0xAAAA,0xBBBB,0xCC00 with mod=1 -> 0xAAAABBBB (sop), then 0xCC000000 with eop, tx_mod=3.
- Both channels each hold 2 packets -> output order ch0,ch1,ch0,ch1; with TX_PKT_MUX_STRICT_PRIO_EN the order is ch0,ch0,ch1,ch1.
- tx_rdy low for 5 cycles mid-packet -> at most 1 tx_vld during the stall; no data lost or duplicated; packing resumes correctly.
- Fill ch0 with 64 words without eop, then 1 more din_vld -> din_rdy[0]=0, ovf_err[0]=1, and no packet is arbitrated from ch0.
- Reset asserted during SEND of a 10-word packet -> all outputs 0 immediately; after release no tx_vld until a new complete packet is written.
